// File: rtl/ika87ad_opfetch_seq.sv
// rtl/ika87ad_opfetch_seq.sv - opcode fetch/prefix sequencer feeding the decoder and microcode engine
module ika87ad_opfetch_seq #(
    parameter logic [7:0] HARDI_OP = 8'h73,
    parameter logic [7:0] NOP_OP   = 8'h00
) (
    input  logic       i_EMUCLK,
    input  logic       i_RESET,
    output logic       o_FETCH_REQ,
    output logic       o_FETCH_M1,
    input  logic       i_FETCH_ACK,
    input  logic [7:0] i_FETCH_DATA,
    output logic       o_PC_INC,
    output logic [7:0] o_OPCODE,
    output logic [2:0] o_OPCODE_PAGE,
    output logic       o_DEC_VALID,
    input  logic       i_DEC_READY,
    output logic       o_DEC_SKIP,
    input  logic       i_INSN_DONE,
    input  logic       i_SKIP_NEXT,
    input  logic       i_IRQ_PEND,
    output logic       o_IRQ_ACK
);

    typedef enum logic [2:0] {
        ST_BOUND  = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_EXEC   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [2:0] page_q, page_d;
    logic       dec_skip_q, dec_skip_d;
    logic       skip_flag_q, skip_flag_d;
    logic       irq_tag_q, irq_tag_d;
    logic       pc_inc_q, pc_inc_d;
    logic       irq_ack_q, irq_ack_d;

    logic       fetch_ack;
    logic       accept;
    logic [2:0] prefix_page;

    // Page codes must line up with the decoder's page input.
    always_comb begin
        prefix_page = 3'd0;
        case (i_FETCH_DATA)
            8'h48:   prefix_page = 3'd1;
            8'h60:   prefix_page = 3'd2;
            8'h64:   prefix_page = 3'd3;
            8'h70:   prefix_page = 3'd4;
            8'h74:   prefix_page = 3'd5;
            default: prefix_page = 3'd0;
        endcase
    end

    assign fetch_ack = i_FETCH_ACK && (state_q == ST_FETCH1 || state_q == ST_FETCH2);
    assign accept    = (state_q == ST_ISSUE) && i_DEC_READY;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        page_d      = page_q;
        dec_skip_d  = dec_skip_q;
        irq_tag_d   = irq_tag_q;
        pc_inc_d    = fetch_ack;
        irq_ack_d   = accept && irq_tag_q;
        // A skip request in the accept cycle belongs to the following instruction.
        skip_flag_d = accept ? i_SKIP_NEXT : (skip_flag_q || i_SKIP_NEXT);

        case (state_q)
            ST_BOUND: begin
                if (i_IRQ_PEND && !skip_flag_q) begin
                    opcode_d   = HARDI_OP;
                    page_d     = 3'd0;
                    irq_tag_d  = 1'b1;
                    dec_skip_d = 1'b0;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_FETCH1;
                end
            end
            ST_FETCH1: begin
                if (i_FETCH_ACK) begin
                    if (prefix_page != 3'd0) begin
                        page_d  = prefix_page;
                        state_d = ST_FETCH2;
                    end else begin
                        page_d     = 3'd0;
                        opcode_d   = i_FETCH_DATA;
                        irq_tag_d  = 1'b0;
                        dec_skip_d = skip_flag_q || i_SKIP_NEXT;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_FETCH2: begin
                if (i_FETCH_ACK) begin
                    opcode_d   = i_FETCH_DATA;
                    irq_tag_d  = 1'b0;
                    dec_skip_d = skip_flag_q || i_SKIP_NEXT;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_DEC_READY) begin
                    dec_skip_d = 1'b0;
                    irq_tag_d  = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (i_INSN_DONE) begin
                    state_d = ST_BOUND;
                end
            end
            default: state_d = ST_BOUND;
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RESET) begin
            state_q     <= ST_BOUND;
            opcode_q    <= NOP_OP;
            page_q      <= 3'd0;
            dec_skip_q  <= 1'b0;
            skip_flag_q <= 1'b0;
            irq_tag_q   <= 1'b0;
            pc_inc_q    <= 1'b0;
            irq_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            page_q      <= page_d;
            dec_skip_q  <= dec_skip_d;
            skip_flag_q <= skip_flag_d;
            irq_tag_q   <= irq_tag_d;
            pc_inc_q    <= pc_inc_d;
            irq_ack_q   <= irq_ack_d;
        end
    end

    assign o_FETCH_REQ   = (state_q == ST_FETCH1) || (state_q == ST_FETCH2);
    assign o_FETCH_M1    = (state_q == ST_FETCH1);
    assign o_PC_INC      = pc_inc_q;
    assign o_IRQ_ACK     = irq_ack_q;
    assign o_DEC_VALID   = (state_q == ST_ISSUE);
    assign o_OPCODE      = (state_q == ST_ISSUE) ? opcode_q : NOP_OP;
    assign o_OPCODE_PAGE = (state_q == ST_ISSUE) ? page_q : 3'd0;
    assign o_DEC_SKIP    = (state_q == ST_ISSUE) && dec_skip_q;

endmodule

// File: tb/tb_ika87ad_opfetch_seq.sv
// tb/tb_ika87ad_opfetch_seq.sv - bench for ika87ad_opfetch_seq
module tb_ika87ad_opfetch_seq;

    logic       clk = 1'b0;
    logic       i_RESET = 1'b1;
    logic       o_FETCH_REQ, o_FETCH_M1, o_PC_INC, o_DEC_VALID, o_DEC_SKIP, o_IRQ_ACK;
    logic       i_FETCH_ACK = 1'b0;
    logic [7:0] i_FETCH_DATA = 8'h00;
    logic [7:0] o_OPCODE;
    logic [2:0] o_OPCODE_PAGE;
    logic       i_DEC_READY = 1'b0;
    logic       i_INSN_DONE = 1'b0;
    logic       i_SKIP_NEXT = 1'b0;
    logic       i_IRQ_PEND = 1'b0;

    int checks = 0;
    int errors = 0;
    int pc_cnt = 0;
    bit m_skip = 1'b0;

    always #5 clk = ~clk;

    ika87ad_opfetch_seq dut (
        .i_EMUCLK     (clk),
        .i_RESET      (i_RESET),
        .o_FETCH_REQ  (o_FETCH_REQ),
        .o_FETCH_M1   (o_FETCH_M1),
        .i_FETCH_ACK  (i_FETCH_ACK),
        .i_FETCH_DATA (i_FETCH_DATA),
        .o_PC_INC     (o_PC_INC),
        .o_OPCODE     (o_OPCODE),
        .o_OPCODE_PAGE(o_OPCODE_PAGE),
        .o_DEC_VALID  (o_DEC_VALID),
        .i_DEC_READY  (i_DEC_READY),
        .o_DEC_SKIP   (o_DEC_SKIP),
        .i_INSN_DONE  (i_INSN_DONE),
        .i_SKIP_NEXT  (i_SKIP_NEXT),
        .i_IRQ_PEND   (i_IRQ_PEND),
        .o_IRQ_ACK    (o_IRQ_ACK)
    );

    always @(negedge clk) if (o_PC_INC === 1'b1) pc_cnt <= pc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] page_of(input logic [7:0] b);
        case (b)
            8'h48: return 3'd1;
            8'h60: return 3'd2;
            8'h64: return 3'd3;
            8'h70: return 3'd4;
            8'h74: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    task automatic fetch_byte(input logic [7:0] b, input logic m1);
        int d;
        for (int k = 0; k < 20 && o_FETCH_REQ !== 1'b1; k++) step();
        chk("fetch_req", o_FETCH_REQ, 1);
        chk("fetch_m1", o_FETCH_M1, m1);
        d = $urandom_range(0, 2);
        for (int k = 0; k < d; k++) begin
            step();
            chk("req_held", {o_FETCH_REQ, o_FETCH_M1}, {1'b1, m1});
        end
        i_FETCH_ACK  = 1'b1;
        i_FETCH_DATA = b;
        step();
        i_FETCH_ACK  = 1'b0;
        i_FETCH_DATA = 8'($urandom);
        chk("pc_inc", o_PC_INC, 1);
    endtask

    // skip_mode: 0 none, 1 SKIP_NEXT during EXEC, 2 SKIP_NEXT in the accept cycle
    task automatic do_insn(input logic [7:0] b0, input logic [7:0] b1, input int stall,
                           input int skip_mode, input bit irq);
        logic [7:0] e_op;
        logic [2:0] e_pg;
        bit         e_skip, e_hardi;
        int         e_bytes, pc0;
        e_hardi = irq && !m_skip;
        e_skip  = e_hardi ? 1'b0 : m_skip;
        if (e_hardi) begin
            e_op = 8'h73; e_pg = 3'd0; e_bytes = 0;
        end else if (page_of(b0) != 3'd0) begin
            e_op = b1; e_pg = page_of(b0); e_bytes = 2;
        end else begin
            e_op = b0; e_pg = 3'd0; e_bytes = 1;
        end
        pc0 = pc_cnt;
        i_IRQ_PEND = irq;
        if (e_hardi) begin
            step();
        end else begin
            fetch_byte(b0, 1'b1);
            if (e_bytes == 2) fetch_byte(b1, 1'b0);
        end
        i_IRQ_PEND = 1'b0;
        chk("dec_valid", o_DEC_VALID, 1);
        chk("opcode", o_OPCODE, e_op);
        chk("page", o_OPCODE_PAGE, e_pg);
        chk("dec_skip", o_DEC_SKIP, e_skip);
        for (int k = 0; k < stall; k++) begin
            i_DEC_READY = 1'b0;
            step();
            chk("stall_hold", {o_DEC_VALID, o_FETCH_REQ, o_OPCODE, o_OPCODE_PAGE, o_DEC_SKIP},
                {1'b1, 1'b0, e_op, e_pg, e_skip});
        end
        if (skip_mode == 2) i_SKIP_NEXT = 1'b1;
        i_DEC_READY = 1'b1;
        step();
        i_DEC_READY = 1'b0;
        i_SKIP_NEXT = 1'b0;
        chk("exec_valid", o_DEC_VALID, 0);
        chk("exec_nop", {o_OPCODE, o_OPCODE_PAGE}, 11'd0);
        chk("irq_ack", o_IRQ_ACK, e_hardi);
        m_skip = (skip_mode != 0);
        step();
        chk("irq_ack_pulse", o_IRQ_ACK, 0);
        if (skip_mode == 1) begin
            i_SKIP_NEXT = 1'b1;
            step();
            i_SKIP_NEXT = 1'b0;
        end
        i_INSN_DONE = 1'b1;
        step();
        i_INSN_DONE = 1'b0;
        chk("pc_inc_count", pc_cnt - pc0, e_bytes);
    endtask

    initial begin
        logic [7:0] b0, b1;
        i_RESET = 1'b1;
        repeat (3) step();
        chk("rst_outs", {o_FETCH_REQ, o_FETCH_M1, o_PC_INC, o_DEC_VALID, o_DEC_SKIP, o_IRQ_ACK}, 6'd0);
        chk("rst_opcode", {o_OPCODE, o_OPCODE_PAGE}, 11'd0);
        i_RESET = 1'b0;

        do_insn(8'h0A, 8'h00, 0, 0, 1'b0);
        do_insn(8'h70, 8'h6A, 0, 0, 1'b0);
        do_insn(8'h3C, 8'h00, 5, 0, 1'b0);
        do_insn(8'h11, 8'h00, 2, 0, 1'b1);
        do_insn(8'h20, 8'h00, 0, 1, 1'b0);
        do_insn(8'h21, 8'h00, 1, 0, 1'b1);
        do_insn(8'h22, 8'h00, 0, 0, 1'b1);
        do_insn(8'h48, 8'h74, 0, 2, 1'b0);
        do_insn(8'h60, 8'h33, 3, 0, 1'b1);
        do_insn(8'h74, 8'h48, 0, 0, 1'b0);

        // Reset taken while FETCH2 waits after a 64h prefix
        fetch_byte(8'h64, 1'b1);
        chk("in_fetch2", {o_FETCH_REQ, o_FETCH_M1}, 2'b10);
        i_RESET = 1'b1;
        step();
        chk("rst2_outs", {o_FETCH_REQ, o_FETCH_M1, o_PC_INC, o_DEC_VALID, o_DEC_SKIP, o_IRQ_ACK}, 6'd0);
        chk("rst2_opcode", {o_OPCODE, o_OPCODE_PAGE}, 11'd0);
        i_RESET = 1'b0;
        m_skip = 1'b0;
        do_insn(8'h10, 8'h00, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: b0 = 8'h48;
                1: b0 = 8'h60;
                2: b0 = 8'h64;
                3: b0 = 8'h70;
                4: b0 = 8'h74;
                default: b0 = 8'($urandom);
            endcase
            b1 = ($urandom_range(0, 3) == 0) ? 8'h70 : 8'($urandom);
            do_insn(b0, b1, $urandom_range(0, 4), $urandom_range(0, 2), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
